// File: rtl/sdram_cmd_sched_pkg.sv
// sdram_cmd_sched_pkg
// Shared definitions for the SDRAM command scheduler and the command
// generator that consumes its output: command codes, bus widths, the
// default mode-register value and the scheduler FSM state encoding.
package sdram_cmd_sched_pkg;

    localparam int ROW_W_DEF = 11;
    localparam int ADDR_W    = 11;
    localparam int COL_W     = 8;
    localparam int TIMER_W   = 16;

    // CAS latency 3, burst length 4.
    localparam logic [ADDR_W-1:0] MODE_REG_DEF = 11'h032;
    // A10 high selects "all banks" for a precharge.
    localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = 11'h400;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_ACT     = 3'b001,
        CMD_READ    = 3'b010,
        CMD_WRITE   = 3'b011,
        CMD_PRE_ALL = 3'b100,
        CMD_PRE_ONE = 3'b101,
        CMD_REFRESH = 3'b110,
        CMD_MRS     = 3'b111
    } cmd_e;

    typedef enum logic [3:0] {
        ST_INIT_WAIT = 4'd0,
        ST_INIT_PRE  = 4'd1,
        ST_INIT_REF1 = 4'd2,
        ST_INIT_REF2 = 4'd3,
        ST_INIT_MRS  = 4'd4,
        ST_IDLE      = 4'd5,
        ST_REF_PRE   = 4'd6,
        ST_REF_REF   = 4'd7,
        ST_ACC_PRE   = 4'd8,
        ST_ACC_ACT   = 4'd9,
        ST_ACC_RW    = 4'd10
    } state_e;

    // Timer reload for a state that must last t cycles (issue cycle included).
    function automatic logic [TIMER_W-1:0] waitLoad(input int t);
        return TIMER_W'(t - 1);
    endfunction

endpackage

// File: rtl/sdram_cmd_sched_open_row_table.sv
// sdram_open_row_table
// Per-bank open-row tracker: 4 entries, each an open flag plus the row that
// was activated. Lookup is combinational so the scheduler can classify a
// request (hit / closed / conflict) in the same cycle it sees it.
// Ports:
//   sclk, sreset          clock, synchronous active-high reset (clears flags)
//   setEn/setBank/setRow  mark a bank open with the given row (ACT)
//   clrOneEn/clrBank      close one bank (PRE_ONE)
//   clrAllEn              close every bank (PRE_ALL / REFRESH), has priority
//   lookBank/lookRow      lookup key
//   lookOpen              looked-up bank is open
//   lookHit               looked-up bank is open on exactly lookRow
//   anyOpen               at least one bank is open
module sdram_open_row_table #(
    parameter int ROW_W = 11
) (
    input  logic             sclk,
    input  logic             sreset,
    input  logic             setEn,
    input  logic [1:0]       setBank,
    input  logic [ROW_W-1:0] setRow,
    input  logic             clrOneEn,
    input  logic [1:0]       clrBank,
    input  logic             clrAllEn,
    input  logic [1:0]       lookBank,
    input  logic [ROW_W-1:0] lookRow,
    output logic             lookOpen,
    output logic             lookHit,
    output logic             anyOpen
);

    logic [3:0]       openFlag;
    logic [ROW_W-1:0] rowMem [4];

    always_ff @(posedge sclk) begin
        if (sreset) begin
            openFlag <= '0;
            for (int i = 0; i < 4; i++) begin
                rowMem[i] <= '0;
            end
        end else begin
            if (clrAllEn) begin
                openFlag <= '0;
            end else begin
                if (clrOneEn) begin
                    openFlag[clrBank] <= 1'b0;
                end
                if (setEn) begin
                    openFlag[setBank] <= 1'b1;
                end
            end
            if (setEn) begin
                rowMem[setBank] <= setRow;
            end
        end
    end

    assign lookOpen = openFlag[lookBank];
    assign lookHit  = openFlag[lookBank] && (rowMem[lookBank] == lookRow);
    assign anyOpen  = |openFlag;

endmodule

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched
// SDRAM command scheduler. Runs the power-up init sequence (wait, PRE_ALL,
// two REFRESH, MRS), then services periodic auto-refresh and converts access
// requests into PRE/ACT/READ/WRITE sequences while enforcing tRP, tRCD, tRFC
// and tMRD.
// Ports:
//   sclk, sreset      clock, synchronous active-high reset
//   iReq..iReqCol     access request (valid + write flag, bank, row, column)
//   oReqAck           1-cycle pulse in the cycle the READ/WRITE is issued
//   oCmdVld           1-cycle pulse, a command is on oCmd/oCmdBank/oCmdAddr
//   oCmd              command code (NOP when oCmdVld is low)
//   oCmdBank          bank for the command
//   oCmdAddr          address bus value for the command
//   oInitDone         init sequence complete, sticky until reset
//   oRefPending       an auto-refresh is owed
//   oDbgState         current FSM state
//
// Request handshake: iReq is the valid; oReqAck is the ready/accept pulse.
// The requester holds iReq with stable fields until it sees oReqAck; the
// transfer completes in the oReqAck cycle. If iReq is still high in the
// following cycle it is a new request.
module sdram_cmd_sched
    import sdram_cmd_sched_pkg::*;
#(
    parameter int                ROW_W    = ROW_W_DEF,
    parameter int                T_INIT   = 100,
    parameter int                T_RP     = 3,
    parameter int                T_RCD    = 3,
    parameter int                T_RFC    = 7,
    parameter int                T_MRD    = 2,
    parameter int                T_REF    = 780,
    parameter logic [ADDR_W-1:0] MODE_REG = MODE_REG_DEF
) (
    input  logic              sclk,
    input  logic              sreset,
    input  logic              iReq,
    input  logic              iReqWr,
    input  logic [1:0]        iReqBank,
    input  logic [ROW_W-1:0]  iReqRow,
    input  logic [COL_W-1:0]  iReqCol,
    output logic              oReqAck,
    output logic              oCmdVld,
    output logic [2:0]        oCmd,
    output logic [1:0]        oCmdBank,
    output logic [ADDR_W-1:0] oCmdAddr,
    output logic              oInitDone,
    output logic              oRefPending,
    output logic [3:0]        oDbgState
);

    state_e               state, nextState;
    logic [TIMER_W-1:0]   timer, timerNext;
    // Low only in the first cycle of a state: that cycle carries the command.
    logic                 issued;
    logic                 initDone;
    logic [TIMER_W-1:0]   refCnt;
    logic                 refPending;

    logic                 reqWr;
    logic [1:0]           reqBank;
    logic [ROW_W-1:0]     reqRow;
    logic [COL_W-1:0]     reqCol;

    cmd_e                 cmdC;
    logic [1:0]           bankC;
    logic [ADDR_W-1:0]    addrC;
    logic                 ackC;
    logic                 accept;
    logic                 tblSet;
    logic                 tblClrOne;
    logic                 tblClrAll;
    logic                 refIssued;
    logic                 initEnter;

    logic                 lookOpen;
    logic                 lookHit;
    logic                 anyOpen;

    sdram_open_row_table #(.ROW_W(ROW_W)) uOpenRows (
        .sclk     (sclk),
        .sreset   (sreset),
        .setEn    (tblSet),
        .setBank  (reqBank),
        .setRow   (reqRow),
        .clrOneEn (tblClrOne),
        .clrBank  (reqBank),
        .clrAllEn (tblClrAll),
        .lookBank (iReqBank),
        .lookRow  (iReqRow),
        .lookOpen (lookOpen),
        .lookHit  (lookHit),
        .anyOpen  (anyOpen)
    );

    always_ff @(posedge sclk) begin
        if (sreset) begin
            state      <= ST_INIT_WAIT;
            timer      <= waitLoad(T_INIT);
            issued     <= 1'b0;
            initDone   <= 1'b0;
            refCnt     <= waitLoad(T_REF);
            refPending <= 1'b0;
            reqWr      <= 1'b0;
            reqBank    <= '0;
            reqRow     <= '0;
            reqCol     <= '0;
        end else begin
            state  <= nextState;
            timer  <= timerNext;
            issued <= (nextState == state);

            if (initEnter) begin
                initDone <= 1'b1;
            end

            // Refresh interval counter only runs once init has completed.
            if (initEnter) begin
                refCnt <= waitLoad(T_REF);
            end else if (initDone) begin
                if (refCnt == '0) begin
                    refCnt <= waitLoad(T_REF);
                end else begin
                    refCnt <= refCnt - 1'b1;
                end
            end

            // A new expiry in the same cycle as the REFRESH issue stays owed.
            if (refIssued) begin
                refPending <= 1'b0;
            end
            if (initDone && !initEnter && (refCnt == '0)) begin
                refPending <= 1'b1;
            end

            if (accept) begin
                reqWr   <= iReqWr;
                reqBank <= iReqBank;
                reqRow  <= iReqRow;
                reqCol  <= iReqCol;
            end
        end
    end

    always_comb begin
        nextState = state;
        timerNext = (timer == '0) ? timer : timer - 1'b1;
        cmdC      = CMD_NOP;
        bankC     = '0;
        addrC     = '0;
        ackC      = 1'b0;
        accept    = 1'b0;
        tblSet    = 1'b0;
        tblClrOne = 1'b0;
        tblClrAll = 1'b0;
        refIssued = 1'b0;
        initEnter = 1'b0;

        case (state)
            ST_INIT_WAIT: begin
                if (timer == '0) begin
                    nextState = ST_INIT_PRE;
                    timerNext = waitLoad(T_RP);
                end
            end
            ST_INIT_PRE: begin
                if (!issued) begin
                    cmdC      = CMD_PRE_ALL;
                    addrC     = ADDR_PRE_ALL;
                    tblClrAll = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_INIT_REF1;
                    timerNext = waitLoad(T_RFC);
                end
            end
            ST_INIT_REF1: begin
                if (!issued) begin
                    cmdC      = CMD_REFRESH;
                    tblClrAll = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_INIT_REF2;
                    timerNext = waitLoad(T_RFC);
                end
            end
            ST_INIT_REF2: begin
                if (!issued) begin
                    cmdC      = CMD_REFRESH;
                    tblClrAll = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_INIT_MRS;
                    timerNext = waitLoad(T_MRD);
                end
            end
            ST_INIT_MRS: begin
                if (!issued) begin
                    cmdC  = CMD_MRS;
                    addrC = MODE_REG;
                end
                if (timer == '0) begin
                    nextState = ST_IDLE;
                    initEnter = 1'b1;
                end
            end
            ST_IDLE: begin
                // Refresh has priority over a waiting access.
                if (refPending) begin
                    if (anyOpen) begin
                        nextState = ST_REF_PRE;
                        timerNext = waitLoad(T_RP);
                    end else begin
                        nextState = ST_REF_REF;
                        timerNext = waitLoad(T_RFC);
                    end
                end else if (iReq) begin
                    accept = 1'b1;
                    if (lookHit) begin
                        nextState = ST_ACC_RW;
                    end else if (lookOpen) begin
                        nextState = ST_ACC_PRE;
                        timerNext = waitLoad(T_RP);
                    end else begin
                        nextState = ST_ACC_ACT;
                        timerNext = waitLoad(T_RCD);
                    end
                end
            end
            ST_REF_PRE: begin
                if (!issued) begin
                    cmdC      = CMD_PRE_ALL;
                    addrC     = ADDR_PRE_ALL;
                    tblClrAll = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_REF_REF;
                    timerNext = waitLoad(T_RFC);
                end
            end
            ST_REF_REF: begin
                if (!issued) begin
                    cmdC      = CMD_REFRESH;
                    tblClrAll = 1'b1;
                    refIssued = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_IDLE;
                end
            end
            ST_ACC_PRE: begin
                // A10 low: precharge only the addressed bank.
                if (!issued) begin
                    cmdC      = CMD_PRE_ONE;
                    bankC     = reqBank;
                    tblClrOne = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_ACC_ACT;
                    timerNext = waitLoad(T_RCD);
                end
            end
            ST_ACC_ACT: begin
                if (!issued) begin
                    cmdC   = CMD_ACT;
                    bankC  = reqBank;
                    addrC  = ADDR_W'(reqRow);
                    tblSet = 1'b1;
                end
                if (timer == '0) begin
                    nextState = ST_ACC_RW;
                end
            end
            ST_ACC_RW: begin
                // A10 low: no autoprecharge, the row stays open for hits.
                cmdC      = reqWr ? CMD_WRITE : CMD_READ;
                bankC     = reqBank;
                addrC     = {3'b000, reqCol};
                ackC      = 1'b1;
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_INIT_WAIT;
                timerNext = waitLoad(T_INIT);
            end
        endcase
    end

    assign oCmd        = cmdC;
    assign oCmdVld     = (cmdC != CMD_NOP);
    assign oCmdBank    = bankC;
    assign oCmdAddr    = addrC;
    assign oReqAck     = ackC;
    assign oInitDone   = initDone;
    assign oRefPending = refPending;
    assign oDbgState   = state;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed testbench for sdram_cmd_sched. Cycle numbers count clock edges
// after the last edge that sampled sreset high.
module tb_sdram_cmd_sched;
    import sdram_cmd_sched_pkg::*;

    logic        sclk = 1'b0;
    logic        sreset = 1'b1;
    logic        iReq = 1'b0;
    logic        iReqWr = 1'b0;
    logic [1:0]  iReqBank = '0;
    logic [10:0] iReqRow = '0;
    logic [7:0]  iReqCol = '0;
    logic        oReqAck;
    logic        oCmdVld;
    logic [2:0]  oCmd;
    logic [1:0]  oCmdBank;
    logic [10:0] oCmdAddr;
    logic        oInitDone;
    logic        oRefPending;
    logic [3:0]  oDbgState;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;

    sdram_cmd_sched dut (
        .sclk        (sclk),
        .sreset      (sreset),
        .iReq        (iReq),
        .iReqWr      (iReqWr),
        .iReqBank    (iReqBank),
        .iReqRow     (iReqRow),
        .iReqCol     (iReqCol),
        .oReqAck     (oReqAck),
        .oCmdVld     (oCmdVld),
        .oCmd        (oCmd),
        .oCmdBank    (oCmdBank),
        .oCmdAddr    (oCmdAddr),
        .oInitDone   (oInitDone),
        .oRefPending (oRefPending),
        .oDbgState   (oDbgState)
    );

    // Clock / reset
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) begin
            tick();
        end
    endtask

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkCmd(input string tag, input cmd_e cmd, input logic [1:0] bank,
                            input logic [10:0] addr, input logic ack);
        check({tag, "_vld"},  32'(oCmdVld),  32'(cmd != CMD_NOP));
        check({tag, "_cmd"},  32'(oCmd),     32'(cmd));
        check({tag, "_bank"}, 32'(oCmdBank), 32'(bank));
        check({tag, "_addr"}, 32'(oCmdAddr), 32'(addr));
        check({tag, "_ack"},  32'(oReqAck),  32'(ack));
    endtask

    task automatic checkNop(input string tag);
        check({tag, "_vld"}, 32'(oCmdVld), 32'd0);
        check({tag, "_cmd"}, 32'(oCmd),    32'(CMD_NOP));
        check({tag, "_ack"}, 32'(oReqAck), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkNop(tag);
        check({tag, "_bank"},  32'(oCmdBank),    32'd0);
        check({tag, "_addr"},  32'(oCmdAddr),    32'd0);
        check({tag, "_init"},  32'(oInitDone),   32'd0);
        check({tag, "_refp"},  32'(oRefPending), 32'd0);
        check({tag, "_state"}, 32'(oDbgState),   32'(ST_INIT_WAIT));
    endtask

    // Driver
    task automatic driveReq(input logic wr, input logic [1:0] bank,
                            input logic [10:0] row, input logic [7:0] col);
        iReq     = 1'b1;
        iReqWr   = wr;
        iReqBank = bank;
        iReqRow  = row;
        iReqCol  = col;
    endtask

    initial begin
        // Reset held for three edges
        tick();
        tick();
        checkReset("reset");
        tick();
        cyc = 0;
        sreset = 1'b0;

        // Init sequence
        runTo(99);
        checkNop("init_wait_99");
        runTo(100);
        checkCmd("init_pre_all", CMD_PRE_ALL, 2'd0, 11'h400, 1'b0);
        runTo(101);
        checkNop("init_wait_101");
        runTo(103);
        checkCmd("init_ref1", CMD_REFRESH, 2'd0, 11'h000, 1'b0);
        runTo(110);
        checkCmd("init_ref2", CMD_REFRESH, 2'd0, 11'h000, 1'b0);
        runTo(117);
        checkCmd("init_mrs", CMD_MRS, 2'd0, 11'h032, 1'b0);
        check("init_done_117", 32'(oInitDone), 32'd0);
        runTo(118);
        checkNop("init_wait_118");
        check("init_done_118", 32'(oInitDone), 32'd0);
        runTo(119);
        check("init_done_119", 32'(oInitDone), 32'd1);
        check("idle_119", 32'(oDbgState), 32'(ST_IDLE));

        // Read to a closed bank: ACT, then READ 3 cycles later
        driveReq(1'b0, 2'd1, 11'd5, 8'h10);
        runTo(120);
        checkCmd("rd_act", CMD_ACT, 2'd1, 11'd5, 1'b0);
        runTo(121);
        checkNop("rd_gap_121");
        runTo(122);
        checkNop("rd_gap_122");
        runTo(123);
        checkCmd("rd_read", CMD_READ, 2'd1, 11'h010, 1'b1);

        // Same request again: row hit, READ one cycle after sampling
        runTo(124);
        checkNop("hit_idle");
        runTo(125);
        checkCmd("hit_read", CMD_READ, 2'd1, 11'h010, 1'b1);

        // Write to bank 1 row 9 while row 5 is open: conflict
        driveReq(1'b1, 2'd1, 11'd9, 8'h22);
        runTo(126);
        checkNop("cf_idle");
        runTo(127);
        checkCmd("cf_pre_one", CMD_PRE_ONE, 2'd1, 11'h000, 1'b0);
        runTo(128);
        checkNop("cf_gap_128");
        runTo(130);
        checkCmd("cf_act", CMD_ACT, 2'd1, 11'd9, 1'b0);
        runTo(132);
        checkNop("cf_gap_132");
        runTo(133);
        checkCmd("cf_write", CMD_WRITE, 2'd1, 11'h022, 1'b1);
        iReq = 1'b0;
        runTo(134);
        checkNop("cf_after");
        runTo(135);
        checkNop("idle_no_req");
        check("refp_135", 32'(oRefPending), 32'd0);

        // Access in flight across the refresh expiry at cycle 899
        runTo(896);
        check("refp_896", 32'(oRefPending), 32'd0);
        driveReq(1'b0, 2'd2, 11'd7, 8'h03);
        runTo(897);
        checkCmd("ref_acc_act", CMD_ACT, 2'd2, 11'd7, 1'b0);
        runTo(898);
        check("refp_898", 32'(oRefPending), 32'd0);
        runTo(899);
        check("refp_899", 32'(oRefPending), 32'd1);
        checkNop("ref_acc_gap");
        runTo(900);
        checkCmd("ref_acc_read", CMD_READ, 2'd2, 11'h003, 1'b1);
        // iReq stays high with the same fields
        runTo(901);
        checkNop("ref_idle_901");
        check("refp_901", 32'(oRefPending), 32'd1);
        runTo(902);
        checkCmd("ref_pre_all", CMD_PRE_ALL, 2'd0, 11'h400, 1'b0);
        runTo(903);
        checkNop("ref_gap_903");
        runTo(905);
        checkCmd("ref_refresh", CMD_REFRESH, 2'd0, 11'h000, 1'b0);
        check("refp_905", 32'(oRefPending), 32'd1);
        runTo(906);
        check("refp_906", 32'(oRefPending), 32'd0);
        checkNop("ref_gap_906");
        runTo(912);
        checkNop("ref_idle_912");
        check("ref_state_912", 32'(oDbgState), 32'(ST_IDLE));
        runTo(913);
        checkCmd("post_ref_act", CMD_ACT, 2'd2, 11'd7, 1'b0);
        runTo(916);
        checkCmd("post_ref_read", CMD_READ, 2'd2, 11'h003, 1'b1);
        iReq = 1'b0;

        // Reset between ACT and READ
        runTo(917);
        driveReq(1'b0, 2'd3, 11'd1, 8'h04);
        runTo(918);
        checkCmd("rst_act", CMD_ACT, 2'd3, 11'd1, 1'b0);
        sreset = 1'b1;
        iReq = 1'b0;
        tick();
        cyc = 0;
        sreset = 1'b0;
        checkReset("mid_reset");
        for (int i = 1; i <= 5; i++) begin
            runTo(i);
            checkNop("rst_no_read");
            check("rst_init_low", 32'(oInitDone), 32'd0);
        end
        runTo(99);
        checkNop("reinit_wait_99");
        runTo(100);
        checkCmd("reinit_pre_all", CMD_PRE_ALL, 2'd0, 11'h400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_sched.md
# sdram_cmd_sched

SDRAM command scheduler between the ROB read side and the SDRAM command generator. It runs the power-up init sequence and the periodic auto-refresh. It tracks the open row per bank and turns each access request into the legal PRE/ACT/READ/WRITE sequence, enforcing tRP, tRCD, tRFC and tMRD. The command generator drives its pins from `oCmd`/`oCmdBank`/`oCmdAddr` whenever `oCmdVld` is high.

## Interface
- `ROW_W`, 11: row address width, equal to `` `ROW_W ``.
- `T_INIT`, 100: power-up wait in cycles before the first command.
- `T_RP`, 3: precharge-to-next-command cycles.
- `T_RCD`, 3: ACT-to-READ/WRITE cycles.
- `T_RFC`, 7: REFRESH-to-next-command cycles.
- `T_MRD`, 2: MRS-to-next-command cycles.
- `T_REF`, 780: refresh interval in cycles.
- `MODE_REG`, 11'h032: value placed on the address bus for MRS (CAS 3, burst 4).

Ports:
- `sclk` in 1: the single clock.
- `sreset` in 1: synchronous, active-high reset.
- `iReq` in 1: access request valid; must hold with stable fields until `oReqAck`.
- `iReqWr` in 1: 1 = write, 0 = read.
- `iReqBank` in 2: target bank.
- `iReqRow` in ROW_W: target row.
- `iReqCol` in 8: target column.
- `oReqAck` out 1: one-cycle pulse, asserted in the same cycle as the READ/WRITE command for the request.
- `oCmdVld` out 1: one-cycle pulse, a command is present on `oCmd`.
- `oCmd` out 3: command code; NOP when `oCmdVld` is low.
- `oCmdBank` out 2: bank for the command.
- `oCmdAddr` out 11: address for the command.
- `oInitDone` out 1: high once the init sequence has completed; stays high until reset.
- `oRefPending` out 1: a refresh is owed.

## Operation
- Command codes:
  - NOP 000, ACT 001, READ 010, WRITE 011.
  - PRE_ALL 100, PRE_ONE 101, REFRESH 110, MRS 111.
- Reset values: all outputs 0 and `oCmd` = NOP. State = INIT_WAIT, timer = T_INIT-1. All bank-open flags cleared, refresh counter held.
- Every command is issued as a 1-cycle `oCmdVld` pulse. The state then loads the 16-bit timer with t-1 and waits until the timer reaches 0. Other cycles output NOP.
- Init sequence:
  - INIT_WAIT.
  - INIT_PRE: PRE_ALL with addr bit10 = 1, then wait T_RP.
  - INIT_REF1: REFRESH, then wait T_RFC.
  - INIT_REF2: REFRESH, then wait T_RFC.
  - INIT_MRS: MRS with addr = MODE_REG, then wait T_MRD.
  - IDLE; `oInitDone` goes 1 on entry to IDLE.
- Refresh counter: 16-bit down counter, loaded with T_REF-1 when `oInitDone` rises. At 0 it sets `oRefPending` and reloads. A further expiry while pending is absorbed (single flag, no count).
- In IDLE, refresh pending wins over `iReq`:
  - If any bank is open: REF_PRE issues PRE_ALL (bit10 = 1) and waits T_RP; otherwise go straight to the next step.
  - REFRESH, then wait T_RFC.
  - On issuing REFRESH: clear `oRefPending` and all open flags.
- In IDLE with `iReq` and no refresh pending:
  - Hit (bank open, row equal): RW issues READ/WRITE with addr = {3'b0, col}; A10 = 0, no autoprecharge.
  - Closed bank: ACT with addr = row, wait T_RCD, then RW.
  - Conflict (bank open, row differs): PRE_ONE with addr bit10 = 0, wait T_RP, then ACT, wait T_RCD, then RW.
- ACT sets the bank's open flag and stores the row. PRE_ONE clears that bank's flag.
- RW returns to IDLE the next cycle, so back-to-back hits issue a command every 2 cycles.
- A refresh expiry during an access sequence does not abort it; it is serviced at the next IDLE.

## Timing
- Request sampled in IDLE at edge N.
  - Hit: READ/WRITE and `oReqAck` valid after edge N+1.
  - Closed bank: ACT at N+1, RW at N+1+T_RCD.
  - Conflict: PRE_ONE at N+1, ACT at N+1+T_RP, RW at N+1+T_RP+T_RCD.
- The first command (PRE_ALL) appears T_INIT cycles after reset deasserts. With defaults, `oInitDone` rises at cycle T_INIT+T_RP+2·T_RFC+T_MRD = 119.
- Reset asserted mid-sequence: outputs go to reset values on the next edge, any in-flight request is dropped (no `oReqAck`), and init restarts.
- `iReq` dropping before ack is illegal; the scheduler does not have to handle it.

## Structure
- Shared defines header `sdram_defines.vh`: the command codes, `` `ROW_W ``, `` `ROB_ITEM_W ``, and the MODE_REG default. The same header is also included by the command generator.
- Sub-module `sdram_open_row_table`:
  - 4 entries, each an open flag plus a row.
  - Ports: set (bank, row), clear one, clear all, and combinational hit/open lookup for `iReqBank`/`iReqRow`.
- Top module contains the FSM, the timer and the refresh counter.

## Test plan
- Reset release, no requests → PRE_ALL (addr 0x400) at cycle 100, REFRESH at 103 and 110, MRS 0x032 at 117, `oInitDone` = 1 at 119.
- After init, read bank 1, row 5, col 0x10 → ACT (bank 1, addr 5), then READ (addr 0x010) 3 cycles later with `oReqAck`. A repeat of the same request → READ 1 cycle after sampling.
- Write bank 1, row 9 while row 5 is open → PRE_ONE bank 1, ACT row 9 at +3, WRITE at +6, one `oReqAck`.
- Hold `iReq` continuously across a refresh expiry → current access completes, then PRE_ALL, REFRESH 3 cycles later, `oRefPending` cleared. The next access re-issues ACT because all banks are closed.
- Assert `sreset` for 1 cycle between ACT and READ → no READ, no `oReqAck`, `oInitDone` = 0, init sequence restarts from INIT_WAIT.
